// File: rtl/tile_raster_sequencer.sv
// Tile buffer owner: sweeps every tile pixel through the painter per triangle, then flushes and clears.
// Define BBOX_CULL_EN to skip triangles whose bounding box misses the tile.
module tile_raster_sequencer #(
  parameter int          TILE_W   = 32,
  parameter int          TILE_H   = 16,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] tri_data,
  input  logic         tri_last,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [8:0]   tile_x0,
  input  logic [7:0]   tile_y0,
  output logic [8:0]   paint_x,
  output logic [7:0]   paint_y,
  output logic [31:0]  paint_pixel,
  output logic [127:0] paint_tri,
  output logic         paint_valid,
  input  logic [8:0]   painted_x,
  input  logic [7:0]   painted_y,
  input  logic [31:0]  painted_pixel,
  input  logic         painted_valid,
  output logic [8:0]   out_x,
  output logic [7:0]   out_y,
  output logic [15:0]  out_color,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int N  = TILE_W * TILE_H;
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(TILE_W);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [31:0]   CLEAR_WORD = {BG_COLOR, 16'hFFFF};

  typedef enum logic [2:0] {CLEAR, IDLE, SWEEP, DRAIN, FLUSH} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [127:0]   tri_reg;
  logic           last_reg, first_reg;
  logic [8:0]     x0_reg;
  logic [7:0]     y0_reg;
  logic           paint_valid_reg;
  logic [8:0]     paint_x_reg;
  logic [7:0]     paint_y_reg;
  logic           out_valid_reg, out_valid_next;
  logic [8:0]     out_x_reg;
  logic [7:0]     out_y_reg;
  logic           accept, flush_done, rd_en, hit;
  logic [IW-1:0]  rd_addr;
  logic [8:0]     rd_x;
  logic [7:0]     rd_y;

  logic [31:0]    mem [N];
  logic [31:0]    ram_q;
  logic           we;
  logic [IW-1:0]  waddr;
  logic [31:0]    wdata;
  logic [8:0]     wb_dx;
  logic [7:0]     wb_dy;

`ifdef BBOX_CULL_EN
  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic [8:0]         org_x;
  logic [7:0]         org_y;
  logic signed [15:0] min_x, max_x, min_y, max_y, lo_x, hi_x, lo_y, hi_y;

  // The origin used for the test is the one this accept would latch.
  always_comb begin
    org_x = first_reg ? tile_x0 : x0_reg;
    org_y = first_reg ? tile_y0 : y0_reg;
    min_x = min3($signed(tri_data[111:96]), $signed(tri_data[79:64]), $signed(tri_data[47:32]));
    max_x = max3($signed(tri_data[111:96]), $signed(tri_data[79:64]), $signed(tri_data[47:32]));
    min_y = min3($signed(tri_data[95:80]), $signed(tri_data[63:48]), $signed(tri_data[31:16]));
    max_y = max3($signed(tri_data[95:80]), $signed(tri_data[63:48]), $signed(tri_data[31:16]));
    lo_x  = $signed(16'(org_x));
    hi_x  = $signed(16'(org_x) + 16'(TILE_W - 1));
    lo_y  = $signed(16'(org_y));
    hi_y  = $signed(16'(org_y) + 16'(TILE_H - 1));
    hit   = (max_x >= lo_x) && (min_x <= hi_x) && (max_y >= lo_y) && (min_y <= hi_y);
  end
`else
  assign hit = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    rd_en          = 1'b0;
    rd_addr        = idx_reg;
    accept         = 1'b0;
    flush_done     = 1'b0;
    case (state_reg)
      CLEAR: begin
        idx_next = idx_reg + IW'(1);
        if (idx_reg == LAST_IDX) state_next = IDLE;
      end
      IDLE: begin
        if (tri_valid) begin
          accept   = 1'b1;
          idx_next = '0;
          if (hit)           state_next = SWEEP;
          else if (tri_last) state_next = DRAIN;
        end
      end
      SWEEP: begin
        rd_en    = 1'b1;
        idx_next = idx_reg + IW'(1);
        if (idx_reg == LAST_IDX) state_next = last_reg ? DRAIN : IDLE;
      end
      DRAIN: begin
        idx_next = idx_reg + IW'(1);
        if (idx_reg[0]) begin
          state_next = FLUSH;
          idx_next   = '0;
        end
      end
      FLUSH: begin
        // idx is the pixel on the output; the read runs one ahead only when it advances.
        if (!out_valid_reg) begin
          rd_en          = 1'b1;
          out_valid_next = 1'b1;
        end else if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            out_valid_next = 1'b0;
            flush_done     = 1'b1;
            idx_next       = '0;
            state_next     = IDLE;
          end else begin
            idx_next = idx_reg + IW'(1);
            rd_en    = 1'b1;
            rd_addr  = idx_reg + IW'(1);
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign rd_x = x0_reg + 9'(rd_addr & IW'(TILE_W - 1));
  assign rd_y = y0_reg + 8'(rd_addr >> LW);

  // Clearing owns the write port; painter write-back uses it otherwise.
  always_comb begin
    wb_dx = painted_x - x0_reg;
    wb_dy = painted_y - y0_reg;
    we    = 1'b0;
    waddr = idx_reg;
    wdata = CLEAR_WORD;
    if (state_reg == CLEAR || (state_reg == FLUSH && out_valid_reg && out_ready)) begin
      we = 1'b1;
    end else if (painted_valid) begin
      we    = 1'b1;
      waddr = (IW'(wb_dy) << LW) | IW'(wb_dx & 9'(TILE_W - 1));
      wdata = painted_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (we)    mem[waddr] <= wdata;
    if (rd_en) ram_q      <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= CLEAR;
      idx_reg         <= '0;
      tri_reg         <= '0;
      last_reg        <= 1'b0;
      first_reg       <= 1'b1;
      x0_reg          <= '0;
      y0_reg          <= '0;
      paint_valid_reg <= 1'b0;
      paint_x_reg     <= '0;
      paint_y_reg     <= '0;
      out_valid_reg   <= 1'b0;
      out_x_reg       <= '0;
      out_y_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      paint_valid_reg <= (state_reg == SWEEP);
      out_valid_reg   <= out_valid_next;
      if (state_reg == SWEEP) begin
        paint_x_reg <= rd_x;
        paint_y_reg <= rd_y;
      end
      if (state_reg == FLUSH && rd_en) begin
        out_x_reg <= rd_x;
        out_y_reg <= rd_y;
      end
      if (accept) begin
        tri_reg   <= tri_data;
        last_reg  <= tri_last;
        first_reg <= 1'b0;
        if (first_reg) begin
          x0_reg <= tile_x0;
          y0_reg <= tile_y0;
        end
      end
      if (flush_done) first_reg <= 1'b1;
    end
  end

  assign tri_ready   = (state_reg == IDLE);
  assign paint_valid = paint_valid_reg;
  assign paint_x     = paint_x_reg;
  assign paint_y     = paint_y_reg;
  assign paint_tri   = tri_reg;
  assign paint_pixel = paint_valid_reg ? ram_q : '0;
  assign out_valid   = out_valid_reg;
  assign out_x       = out_x_reg;
  assign out_y       = out_y_reg;
  assign out_color   = out_valid_reg ? ram_q[31:16] : '0;
endmodule
